// File: rtl/mem_lsu.sv
// Sequential load/store unit between EX/MEM and the data cache: one outstanding
// access, byte-lane alignment, misalignment detection, LL/SC link bit, flush draining.
module mem_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                in_op,
    input  logic [ADDR_WIDTH-1:0]     in_addr,
    input  logic [DATA_WIDTH-1:0]     in_wdata,
    input  logic [REG_ADDR_WIDTH-1:0] in_waddr,
    input  logic                      in_wreg,
    input  logic                      flush_i,
    input  logic                      llbit_clear_i,
    output logic                      req_valid,
    input  logic                      req_ready,
    output logic                      req_we,
    output logic [ADDR_WIDTH-1:0]     req_addr,
    output logic [DATA_WIDTH/8-1:0]   req_wstrb,
    output logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic                      resp_valid,
    input  logic [DATA_WIDTH-1:0]     resp_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_wreg,
    output logic [REG_ADDR_WIDTH-1:0] out_waddr,
    output logic [DATA_WIDTH-1:0]     out_wdata,
    output logic                      out_excp_ale,
    output logic                      llbit_o
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LW = $clog2(NB);

    localparam logic [3:0] OP_LD_B = 4'd1, OP_LD_BU = 4'd2, OP_LD_H = 4'd3, OP_LD_HU = 4'd4;
    localparam logic [3:0] OP_LD_W = 4'd5, OP_ST_B = 4'd6, OP_ST_H = 4'd7, OP_ST_W = 4'd8;
    localparam logic [3:0] OP_LL = 4'd9, OP_SC = 4'd10, OP_LD_D = 4'd11, OP_ST_D = 4'd12;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_DRAIN} state_e;
    state_e state_q, state_d;

    logic [3:0]                op_q, op_d;
    logic [LW-1:0]             lane_q, lane_d;
    logic                      req_valid_q, req_valid_d, req_we_q, req_we_d;
    logic [ADDR_WIDTH-1:0]     req_addr_q, req_addr_d;
    logic [NB-1:0]             req_wstrb_q, req_wstrb_d;
    logic [DATA_WIDTH-1:0]     req_wdata_q, req_wdata_d;
    logic                      out_valid_q, out_valid_d, out_wreg_q, out_wreg_d;
    logic                      out_excp_ale_q, out_excp_ale_d, llbit_q, llbit_d;
    logic [REG_ADDR_WIDTH-1:0] out_waddr_q, out_waddr_d;
    logic [DATA_WIDTH-1:0]     out_wdata_q, out_wdata_d;

    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            OP_LD_H, OP_LD_HU, OP_ST_H:       op_size = 2'd1;
            OP_LD_W, OP_ST_W, OP_LL, OP_SC:   op_size = 2'd2;
            OP_LD_D, OP_ST_D:                 op_size = 2'd3;
            default:                          op_size = 2'd0;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        is_store = op inside {OP_ST_B, OP_ST_H, OP_ST_W, OP_SC, OP_ST_D};
    endfunction

    logic [1:0]            in_sz;
    logic [2:0]            size_m1;
    logic                  in_mem, in_ale, in_direct, accept, q_store;
    logic [LW-1:0]         in_lane;
    logic [15:0]           in_mask_w, in_strb_w;
    logic [DATA_WIDTH-1:0] in_wrep, resp_sh, load_val;

    assign in_ready = rst && (state_q == S_IDLE) && !out_valid_q;
    assign accept   = in_valid && in_ready && !flush_i;
    assign q_store  = is_store(op_q);

    // Request decode; misaligned, NOP and doomed SC complete without touching the cache.
    always_comb begin
        in_sz     = op_size(in_op);
        in_mem    = (in_op >= OP_LD_B) && (in_op <= OP_ST_D);
        size_m1   = 3'((4'd1 << in_sz) - 4'd1);
        in_ale    = in_mem && (((in_addr[2:0] & size_m1) != 3'd0) ||
                               (in_sz == 2'd3 && DATA_WIDTH == 32));
        in_direct = in_ale || !in_mem || (in_op == OP_SC && !llbit_q);
        in_lane   = in_addr[LW-1:0];
        in_mask_w = (16'd1 << (4'd1 << in_sz)) - 16'd1;
        in_strb_w = in_mask_w << in_lane;
        in_wrep   = '0;
        for (int i = 0; i < NB; i++)
            in_wrep[8*i +: 8] = in_wdata[8*(i & int'(size_m1)) +: 8];
    end

    always_comb begin
        resp_sh = resp_data >> {lane_q, 3'b000};
        case (op_q)
            OP_LD_B:        load_val = DATA_WIDTH'($signed(resp_sh[7:0]));
            OP_LD_BU:       load_val = DATA_WIDTH'(resp_sh[7:0]);
            OP_LD_H:        load_val = DATA_WIDTH'($signed(resp_sh[15:0]));
            OP_LD_HU:       load_val = DATA_WIDTH'(resp_sh[15:0]);
            OP_LD_W, OP_LL: load_val = DATA_WIDTH'($signed(resp_sh[31:0]));
            default:        load_val = resp_sh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // A load whose handshake coincides with a flush still owes a response, so drain it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = in_direct ? S_RESP : S_REQ;
            S_REQ:   if (flush_i) state_d = (req_ready && !q_store) ? S_DRAIN : S_IDLE;
                     else if (req_ready) state_d = q_store ? S_RESP : S_WAIT;
            S_WAIT:  if (flush_i) state_d = resp_valid ? S_IDLE : S_DRAIN;
                     else if (resp_valid) state_d = S_RESP;
            S_RESP:  if (flush_i || out_ready) state_d = S_IDLE;
            S_DRAIN: if (resp_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d = op_q;               lane_d = lane_q;
        req_valid_d = req_valid_q; req_we_d = req_we_q;       req_addr_d = req_addr_q;
        req_wstrb_d = req_wstrb_q; req_wdata_d = req_wdata_q;
        out_valid_d = out_valid_q; out_wreg_d = out_wreg_q;   out_waddr_d = out_waddr_q;
        out_wdata_d = out_wdata_q; out_excp_ale_d = out_excp_ale_q;
        llbit_d     = llbit_q;
        case (state_q)
            S_IDLE: if (accept) begin
                op_d        = in_op;
                lane_d      = in_lane;
                out_waddr_d = in_waddr;
                if (in_direct) begin
                    out_valid_d    = 1'b1;
                    out_excp_ale_d = in_ale;
                    out_wreg_d     = in_ale ? 1'b0 : (in_mem ? 1'b1 : in_wreg);
                    out_wdata_d    = (in_ale || in_mem) ? '0 : in_wdata;
                end else begin
                    req_valid_d = 1'b1;
                    req_we_d    = is_store(in_op);
                    req_addr_d  = {in_addr[ADDR_WIDTH-1:LW], {LW{1'b0}}};
                    req_wstrb_d = in_strb_w[NB-1:0];
                    req_wdata_d = in_wrep;
                end
            end
            S_REQ: if (req_ready || flush_i) begin
                req_valid_d = 1'b0; req_we_d = 1'b0; req_addr_d = '0;
                req_wstrb_d = '0;   req_wdata_d = '0;
                // A handshaked SC has written memory even if flushed.
                if (req_ready && op_q == OP_SC) llbit_d = 1'b0;
                if (req_ready && !flush_i && q_store) begin
                    out_valid_d    = 1'b1;
                    out_excp_ale_d = 1'b0;
                    out_wreg_d     = (op_q == OP_SC);
                    out_wdata_d    = DATA_WIDTH'(op_q == OP_SC);
                end
            end
            S_WAIT: if (resp_valid && !flush_i) begin
                out_valid_d    = 1'b1;
                out_wreg_d     = 1'b1;
                out_excp_ale_d = 1'b0;
                out_wdata_d    = load_val;
                if (op_q == OP_LL) llbit_d = 1'b1;
            end
            S_RESP: if (flush_i || out_ready) begin
                out_valid_d = 1'b0; out_wreg_d = 1'b0; out_waddr_d = '0;
                out_wdata_d = '0;   out_excp_ale_d = 1'b0;
            end
            default: ;
        endcase
        if (llbit_clear_i) llbit_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q <= '0;        lane_q <= '0;
            req_valid_q <= 1'b0; req_we_q <= 1'b0; req_addr_q <= '0;
            req_wstrb_q <= '0;   req_wdata_q <= '0;
            out_valid_q <= 1'b0; out_wreg_q <= 1'b0; out_waddr_q <= '0;
            out_wdata_q <= '0;   out_excp_ale_q <= 1'b0; llbit_q <= 1'b0;
        end else begin
            op_q <= op_d;      lane_q <= lane_d;
            req_valid_q <= req_valid_d; req_we_q <= req_we_d; req_addr_q <= req_addr_d;
            req_wstrb_q <= req_wstrb_d; req_wdata_q <= req_wdata_d;
            out_valid_q <= out_valid_d; out_wreg_q <= out_wreg_d; out_waddr_q <= out_waddr_d;
            out_wdata_q <= out_wdata_d; out_excp_ale_q <= out_excp_ale_d; llbit_q <= llbit_d;
        end
    end

    assign req_valid    = req_valid_q;
    assign req_we       = req_we_q;
    assign req_addr     = req_addr_q;
    assign req_wstrb    = req_wstrb_q;
    assign req_wdata    = req_wdata_q;
    assign out_valid    = out_valid_q;
    assign out_wreg     = out_wreg_q;
    assign out_waddr    = out_waddr_q;
    assign out_wdata    = out_wdata_q;
    assign out_excp_ale = out_excp_ale_q;
    assign llbit_o      = llbit_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: a 32-bit and a 64-bit instance share stimulus; sel picks
// which one a transaction targets and whose outputs are observed.
module tb_mem_lsu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        sel = 1'b0, in_valid = 1'b0, in_wreg = 1'b0;
    logic [3:0]  in_op = '0;
    logic [31:0] in_addr = '0;
    logic [63:0] in_wdata = '0, resp_data = '0;
    logic [4:0]  in_waddr = '0;
    logic        flush = 1'b0, llclr = 1'b0, req_ready = 1'b0, resp_valid = 1'b0, out_ready = 1'b0;

    logic        a_in_ready, a_req_valid, a_req_we, a_out_valid, a_out_wreg, a_ale, a_llbit;
    logic [31:0] a_req_addr, a_req_wdata, a_out_wdata;
    logic [3:0]  a_req_wstrb;
    logic [4:0]  a_out_waddr;
    logic        b_in_ready, b_req_valid, b_req_we, b_out_valid, b_out_wreg, b_ale, b_llbit;
    logic [31:0] b_req_addr;
    logic [63:0] b_req_wdata, b_out_wdata;
    logic [7:0]  b_req_wstrb;
    logic [4:0]  b_out_waddr;

    mem_lsu #(.DATA_WIDTH(32)) u_d32 (
        .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(a_in_ready),
        .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata[31:0]), .in_waddr(in_waddr),
        .in_wreg(in_wreg), .flush_i(flush), .llbit_clear_i(llclr),
        .req_valid(a_req_valid), .req_ready(req_ready), .req_we(a_req_we), .req_addr(a_req_addr),
        .req_wstrb(a_req_wstrb), .req_wdata(a_req_wdata), .resp_valid(resp_valid),
        .resp_data(resp_data[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_wreg(a_out_wreg), .out_waddr(a_out_waddr), .out_wdata(a_out_wdata),
        .out_excp_ale(a_ale), .llbit_o(a_llbit));

    mem_lsu #(.DATA_WIDTH(64)) u_d64 (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(b_in_ready),
        .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata), .in_waddr(in_waddr),
        .in_wreg(in_wreg), .flush_i(flush), .llbit_clear_i(llclr),
        .req_valid(b_req_valid), .req_ready(req_ready), .req_we(b_req_we), .req_addr(b_req_addr),
        .req_wstrb(b_req_wstrb), .req_wdata(b_req_wdata), .resp_valid(resp_valid),
        .resp_data(resp_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_wreg(b_out_wreg), .out_waddr(b_out_waddr), .out_wdata(b_out_wdata),
        .out_excp_ale(b_ale), .llbit_o(b_llbit));

    logic        o_in_ready, o_req_valid, o_req_we, o_out_valid, o_out_wreg, o_ale, o_llbit;
    logic [31:0] o_req_addr;
    logic [7:0]  o_req_wstrb;
    logic [63:0] o_req_wdata, o_out_wdata;
    logic [4:0]  o_out_waddr;
    assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign o_req_valid = sel ? b_req_valid : a_req_valid;
    assign o_req_we    = sel ? b_req_we    : a_req_we;
    assign o_req_addr  = sel ? b_req_addr  : a_req_addr;
    assign o_req_wstrb = sel ? b_req_wstrb : {4'b0, a_req_wstrb};
    assign o_req_wdata = sel ? b_req_wdata : {32'b0, a_req_wdata};
    assign o_out_valid = sel ? b_out_valid : a_out_valid;
    assign o_out_wreg  = sel ? b_out_wreg  : a_out_wreg;
    assign o_out_waddr = sel ? b_out_waddr : a_out_waddr;
    assign o_out_wdata = sel ? b_out_wdata : {32'b0, a_out_wdata};
    assign o_ale       = sel ? b_ale       : a_ale;
    assign o_llbit     = sel ? b_llbit     : a_llbit;

    int n_cmp = 0, n_err = 0;
    bit llbit_m [2];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference view of the op set: access size in bytes (0 = no memory access).
    function automatic int sz_of(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6:         return 1;
            4'd3, 4'd4, 4'd7:         return 2;
            4'd5, 4'd8, 4'd9, 4'd10:  return 4;
            4'd11, 4'd12:             return 8;
            default:                  return 0;
        endcase
    endfunction
    function automatic bit st_of(input logic [3:0] op);
        return op inside {4'd6, 4'd7, 4'd8, 4'd10, 4'd12};
    endfunction
    function automatic bit sgn_of(input logic [3:0] op);
        return op inside {4'd1, 4'd3, 4'd5, 4'd9};
    endfunction

    // One complete transaction with exact cycle timing; called right after a negedge.
    task automatic do_txn(input logic s, input logic [3:0] op, input logic [31:0] addr,
                          input logic [63:0] wd, input logic [4:0] wa, input logic wr,
                          input logic [63:0] rd, input int req_lat, input int resp_lat,
                          input int wb_lat, input logic llc);
        int nb, sz, lane;
        bit mem, ale, scfail, st, chkwd;
        logic [63:0] dmask, e_addr, e_strb, e_wdata, raw, e_wd;
        logic e_wreg, e_ale;
        nb    = s ? 8 : 4;
        dmask = s ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        sz    = sz_of(op);
        mem   = (sz != 0);
        st    = st_of(op);
        lane  = int'(addr % nb);
        ale   = 1'b0;
        if (mem) ale = ((addr % sz) != 0) || (sz == 8 && !s);
        scfail = mem && !ale && op == 4'd10 && !llbit_m[s];
        e_addr = {32'b0, addr} & ~64'(nb - 1);
        e_strb = (((64'd1 << sz) - 64'd1) << lane) & ((64'd1 << nb) - 64'd1);
        e_wdata = '0;
        for (int b = 0; b < nb; b++) if (sz != 0) e_wdata[8*b +: 8] = wd[8*(b % sz) +: 8];
        raw = rd >> (8 * lane);
        if (sz < 8 && sz > 0) begin
            raw &= (64'd1 << (8 * sz)) - 64'd1;
            if (sgn_of(op) && raw[8*sz-1]) raw |= ~((64'd1 << (8 * sz)) - 64'd1);
        end
        raw &= dmask;

        sel = s;
        #1;
        chk("in_ready_idle", o_in_ready, 1);
        in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wd; in_waddr = wa; in_wreg = wr;
        @(negedge clk);
        in_valid = 1'b0;
        if (mem && !ale && !scfail) begin
            for (int c = 0; c <= req_lat; c++) begin
                chk("req_valid", o_req_valid, 1);
                chk("req_we", o_req_we, st);
                chk("req_addr", o_req_addr, e_addr);
                if (st) chk("req_wstrb", o_req_wstrb, e_strb);
                if (st) chk("req_wdata", o_req_wdata, e_wdata);
                if (c == req_lat) req_ready = 1'b1;
                else begin
                    resp_valid = 1'($urandom_range(0, 1));
                    resp_data  = {$urandom, $urandom};
                end
                @(negedge clk);
                req_ready = 1'b0; resp_valid = 1'b0;
            end
            if (op == 4'd10) llbit_m[s] = 1'b0;
            if (!st) begin
                for (int c = 0; c < resp_lat; c++) begin
                    chk("wait_no_out", o_out_valid, 0);
                    @(negedge clk);
                end
                resp_valid = 1'b1; resp_data = rd; llclr = llc;
                @(negedge clk);
                resp_valid = 1'b0; llclr = 1'b0;
                if (llc) begin llbit_m[0] = 1'b0; llbit_m[1] = 1'b0; end
                else if (op == 4'd9) llbit_m[s] = 1'b1;
            end
        end else begin
            chk("no_req", o_req_valid, 0);
        end

        e_ale = 1'b0; e_wd = '0; chkwd = 1'b1;
        if (!mem)            begin e_wreg = wr;   e_wd = wd & dmask; end
        else if (ale)        begin e_wreg = 1'b0; e_ale = 1'b1; chkwd = 1'b0; end
        else if (scfail)     begin e_wreg = 1'b1; e_wd = 64'd0; end
        else if (op == 4'd10) begin e_wreg = 1'b1; e_wd = 64'd1; end
        else if (st)         begin e_wreg = 1'b0; chkwd = 1'b0; end
        else                 begin e_wreg = 1'b1; e_wd = raw; end
        chk("out_valid", o_out_valid, 1);
        chk("out_wreg", o_out_wreg, e_wreg);
        chk("out_waddr", o_out_waddr, wa);
        chk("out_ale", o_ale, e_ale);
        if (chkwd) chk("out_wdata", o_out_wdata, e_wd);
        chk("busy_not_ready", o_in_ready, 0);
        for (int c = 0; c < wb_lat; c++) begin
            @(negedge clk);
            chk("out_hold", o_out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_released", o_out_valid, 0);
        chk("back_idle", o_in_ready, 1);
        chk("llbit", o_llbit, llbit_m[s]);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] addr;
        int r;
        llbit_m[0] = 1'b0; llbit_m[1] = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk("rst_req_valid", o_req_valid, 0);
            chk("rst_out_valid", o_out_valid, 0);
            chk("rst_out_wdata", o_out_wdata, 0);
            chk("rst_llbit", o_llbit, 0);
        end
        rst = 1'b1;
        @(negedge clk);

        do_txn(0, 4'd1, 32'h1003, 64'd0, 5'd3, 1'b1, 64'h80AABBCC, 0, 0, 0, 1'b0);
        do_txn(0, 4'd7, 32'h2002, 64'h1234ABCD, 5'd4, 1'b1, 64'd0, 3, 0, 1, 1'b0);
        do_txn(0, 4'd5, 32'h3001, 64'd0, 5'd5, 1'b1, 64'd0, 0, 0, 0, 1'b0);
        do_txn(0, 4'd11, 32'h3008, 64'd0, 5'd5, 1'b1, 64'd0, 0, 0, 0, 1'b0);
        do_txn(0, 4'd9, 32'h4000, 64'd0, 5'd6, 1'b1, 64'h12345678, 0, 1, 0, 1'b0);
        do_txn(0, 4'd10, 32'h4000, 64'h55, 5'd7, 1'b1, 64'd0, 1, 0, 0, 1'b0);
        do_txn(0, 4'd10, 32'h4000, 64'h55, 5'd7, 1'b1, 64'd0, 0, 0, 0, 1'b0);
        do_txn(0, 4'd9, 32'h4000, 64'd0, 5'd6, 1'b1, 64'hCAFE, 0, 0, 0, 1'b1);
        do_txn(0, 4'd0, 32'h0, 64'hDEADBEEF, 5'd9, 1'b1, 64'd0, 0, 0, 0, 1'b0);

        // Flush while waiting for load data: response must be swallowed.
        sel = 1'b0; in_valid = 1'b1; in_op = 4'd5; in_addr = 32'h6000; in_waddr = 5'd2;
        @(negedge clk); in_valid = 1'b0;
        chk("fw_req", o_req_valid, 1); req_ready = 1'b1;
        @(negedge clk); req_ready = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("fw_drain_out", o_out_valid, 0); chk("fw_drain_busy", o_in_ready, 0);
        @(negedge clk);
        chk("fw_drain_out2", o_out_valid, 0); chk("fw_drain_busy2", o_in_ready, 0);
        resp_valid = 1'b1; resp_data = 64'h11111111;
        @(negedge clk); resp_valid = 1'b0;
        chk("fw_no_out", o_out_valid, 0); chk("fw_idle", o_in_ready, 1);
        do_txn(0, 4'd2, 32'h5001, 64'd0, 5'd8, 1'b1, 64'h0000FF00, 0, 0, 0, 1'b0);

        // Flush before the request handshake.
        in_valid = 1'b1; in_op = 4'd5; in_addr = 32'h6004;
        @(negedge clk); in_valid = 1'b0;
        chk("fr_req", o_req_valid, 1); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("fr_req_drop", o_req_valid, 0); chk("fr_idle", o_in_ready, 1);
        chk("fr_no_out", o_out_valid, 0);

        // Flush while the result waits for writeback.
        in_valid = 1'b1; in_op = 4'd0; in_wdata = 64'h77;
        @(negedge clk); in_valid = 1'b0;
        chk("fo_out", o_out_valid, 1); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("fo_out_drop", o_out_valid, 0); chk("fo_idle", o_in_ready, 1);

        // Flush in the same cycle as a request blocks acceptance.
        in_valid = 1'b1; in_op = 4'd5; in_addr = 32'h6008; flush = 1'b1;
        @(negedge clk); in_valid = 1'b0; flush = 1'b0;
        chk("fa_no_req", o_req_valid, 0); chk("fa_no_out", o_out_valid, 0);
        chk("fa_idle", o_in_ready, 1);

        do_txn(1, 4'd11, 32'h3004, 64'd0, 5'd1, 1'b1, 64'd0, 0, 0, 0, 1'b0);
        do_txn(1, 4'd11, 32'h3008, 64'd0, 5'd1, 1'b1, 64'h0123456789ABCDEF, 1, 1, 0, 1'b0);
        do_txn(1, 4'd5, 32'h3004, 64'd0, 5'd1, 1'b1, 64'h80000001_12345678, 0, 0, 0, 1'b0);
        do_txn(1, 4'd6, 32'h3005, 64'h00000000_000000A5, 5'd1, 1'b1, 64'd0, 0, 0, 0, 1'b0);
        do_txn(1, 4'd12, 32'h3010, 64'hFEDCBA98_76543210, 5'd1, 1'b1, 64'd0, 2, 0, 0, 1'b0);

        // Reset in WAIT with the link bit set; a late response is ignored.
        do_txn(0, 4'd9, 32'h7000, 64'd0, 5'd3, 1'b1, 64'h1, 0, 0, 0, 1'b0);
        sel = 1'b0; in_valid = 1'b1; in_op = 4'd5; in_addr = 32'h7100; in_waddr = 5'd21;
        @(negedge clk); in_valid = 1'b0; req_ready = 1'b1;
        @(negedge clk); req_ready = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("rw_req_valid", o_req_valid, 0); chk("rw_req_addr", o_req_addr, 0);
        chk("rw_out_valid", o_out_valid, 0); chk("rw_out_waddr", o_out_waddr, 0);
        chk("rw_out_wreg", o_out_wreg, 0);   chk("rw_llbit", o_llbit, 0);
        rst = 1'b1; llbit_m[0] = 1'b0; llbit_m[1] = 1'b0;
        resp_valid = 1'b1; resp_data = 64'h2222;
        @(negedge clk); resp_valid = 1'b0;
        chk("rw_late_resp", o_out_valid, 0); chk("rw_idle", o_in_ready, 1);

        for (int t = 0; t < 300; t++) begin
            r  = $urandom_range(0, 19);
            op = (r < 16) ? 4'(r) : ((r < 18) ? 4'd9 : 4'd10);
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[2:0] = 3'b000;
            do_txn(1'($urandom_range(0, 2) == 0), op, addr, {$urandom, $urandom},
                   5'($urandom), 1'($urandom), {$urandom, $urandom},
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                   1'($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
